// File: rtl/irq_controller.sv
// Multi-source interrupt controller with a CPU-bus register block.
// Each asynchronous source is synchronised, edge-detected and latched into
// PENDING. The lowest-index enabled pending source is presented on
// interrupt_vector (index+1, 0 = none) and held until the CPU acknowledges.
//
// Ports:
//   CLOCK_50          system clock
//   KEY0              asynchronous active-low reset
//   irq_src           raw asynchronous interrupt requests (active-high)
//   interrupt_vector  0 = none, k+1 = source k presented
//   interrupt_ack     CPU acknowledge level
//   bus_*             64-bit CPU bus (write strobe, read strobe, read data/done)
//
// Register map (offset from BASE_ADDR):
//   0x00 PENDING (read, write-1-to-clear)
//   0x08 ENABLE  (read/write)
//   0x10 ACTIVE  (read only, current interrupt_vector)
//   0x18 MODE    (read/write, only when IRQ_LEVEL_MODE_EN is defined; bit k = level source)
//
// Optional feature macro: IRQ_LEVEL_MODE_EN
module irq_controller #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned VEC_W     = 4,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0100
) (
    input  logic               CLOCK_50,
    input  logic               KEY0,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [VEC_W-1:0]   interrupt_vector,
    input  logic               interrupt_ack,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data,
    output logic               bus_read_done
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] SLOT_PENDING = 2'd0;
    localparam logic [1:0] SLOT_ENABLE  = 2'd1;
    localparam logic [1:0] SLOT_ACTIVE  = 2'd2;
    localparam logic [1:0] SLOT_MODE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        ACK_WAIT = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] mode_q;
    logic [IDX_W-1:0]   idx_q, win;
    logic [VEC_W-1:0]   vec_q;
    logic [63:0]        rd_data_q, rd_mux;
    logic               rd_done_q;
    logic               addr_hit, wr_hit, rd_hit, ack_clr;
    logic [1:0]         slot;
    logic               unused_bits;

    assign interrupt_vector = vec_q;
    assign bus_read_data    = rd_data_q;
    assign bus_read_done    = rd_done_q;

    // Register block decode: 32-byte window, 8-byte slots.
    assign addr_hit = (bus_address[63:5] == BASE_ADDR[63:5]);
    assign slot     = bus_address[4:3];
    assign wr_hit   = bus_write_enable & addr_hit;
    assign rd_hit   = bus_read_enable & addr_hit;

    assign unused_bits = ^{bus_write_data[63:NUM_SRC], bus_address[2:0]};

    // Synchroniser and edge-detect stages.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise    = sync2_q & ~prev_q;
    assign req     = pending_q & enable_q;
    assign ack_clr = (state_q == PRESENT) && interrupt_ack;

    // Pending update: clears first, then rises, so a same-cycle set always wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_hit && slot == SLOT_PENDING) begin
            pending_d = pending_d & ~bus_write_data[NUM_SRC-1:0];
        end
        if (ack_clr) begin
            pending_d[idx_q] = 1'b0;
        end
        pending_d = pending_d | rise;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (mode_q[k]) begin
                pending_d[k] = sync2_q[k];
            end
        end
    end

    // Lowest index wins.
    always_comb begin
        win = '0;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            if (req[k]) begin
                win = IDX_W'(k);
            end
        end
    end

    // Software-visible control registers.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            pending_q <= '0;
            enable_q  <= '0;
        end else begin
            pending_q <= pending_d;
            if (wr_hit && slot == SLOT_ENABLE) begin
                enable_q <= bus_write_data[NUM_SRC-1:0];
            end
        end
    end

`ifdef IRQ_LEVEL_MODE_EN
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            mode_q <= '0;
        end else if (wr_hit && slot == SLOT_MODE) begin
            mode_q <= bus_write_data[NUM_SRC-1:0];
        end
    end
`else
    assign mode_q = '0;
`endif

    // Presentation FSM; the vector is frozen from PRESENT until ack is released.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        vec_q   <= VEC_W'(win) + VEC_W'(1);
                        idx_q   <= win;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (interrupt_ack) begin
                        vec_q   <= '0;
                        state_q <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (!interrupt_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vec_q   <= '0;
                end
            endcase
        end
    end

    // Read data mux; unused and unimplemented slots read zero.
    always_comb begin
        rd_mux = '0;
        case (slot)
            SLOT_PENDING: rd_mux = 64'(pending_q);
            SLOT_ENABLE:  rd_mux = 64'(enable_q);
            SLOT_ACTIVE:  rd_mux = 64'(vec_q);
            SLOT_MODE:    rd_mux = 64'(mode_q);
            default:      rd_mux = '0;
        endcase
    end

    // Registered read response; data holds when not reading.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            rd_data_q <= '0;
            rd_done_q <= 1'b0;
        end else if (rd_hit) begin
            rd_data_q <= rd_mux;
            rd_done_q <= 1'b1;
        end else begin
            rd_done_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int unsigned N  = 4;
    localparam int unsigned VW = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_1000_0100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic [VW-1:0] vec;
    logic          ack = 1'b0;
    logic [63:0]   addr = '0;
    logic [63:0]   wdata = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [63:0]   rdata;
    logic          rdone;

    always #5 clk = ~clk;

    irq_controller #(.NUM_SRC(N), .VEC_W(VW), .BASE_ADDR(BASE)) dut (
        .CLOCK_50(clk),
        .KEY0(rst_n),
        .irq_src(irq_src),
        .interrupt_vector(vec),
        .interrupt_ack(ack),
        .bus_address(addr),
        .bus_write_data(wdata),
        .bus_write_enable(we),
        .bus_read_enable(re),
        .bus_read_data(rdata),
        .bus_read_done(rdone)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboards: expected vector changes and expected read responses.
    logic [VW-1:0] vec_q[$];
    logic [63:0]   rd_q[$];

    // Behavioural model: a set of pending sources, an enable set, and which
    // source (if any) the CPU is currently being shown.
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_en   = '0;
    logic [N-1:0] m_mode = '0;
    logic [N-1:0] m_lvl  = '0;
    int           m_cur  = -1;
    bit           m_blocked = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] m_vec();
        return (m_cur < 0) ? VW'(0) : VW'(m_cur + 1);
    endfunction

    function automatic void try_present();
        logic [N-1:0] r;
        r = m_pend & m_en;
        if (!m_blocked && m_cur < 0 && r != 0) begin
            for (int k = 0; k < int'(N); k++) begin
                if (r[k]) begin
                    m_cur = k;
                    break;
                end
            end
            vec_q.push_back(m_vec());
        end
    endfunction

    function automatic logic [63:0] m_read(input int off);
        case (off)
            'h00: return 64'(m_pend);
            'h08: return 64'(m_en);
            'h10: return 64'(m_vec());
`ifdef IRQ_LEVEL_MODE_EN
            'h18: return 64'(m_mode);
`endif
            default: return 64'd0;
        endcase
    endfunction

    // Monitor: every vector change and every read completion is scored.
    initial begin
        logic [VW-1:0] last_vec;
        logic          last_done;
        last_vec  = '0;
        last_done = 1'b0;
        forever begin
            @(negedge clk);
            if (vec !== last_vec) begin
                if (vec_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL vec_unexpected: got %0d with no change expected at %0t", vec, $time);
                end else begin
                    check("vec_seq", 64'(vec), 64'(vec_q.pop_front()));
                end
                last_vec = vec;
            end
            if (rdone === 1'b1 && !last_done) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got done with data 0x%0h, none expected at %0t", rdata, $time);
                end else begin
                    check("rd_data", rdata, rd_q.pop_front());
                end
            end
            last_done = rdone;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input int off, input logic [63:0] d);
        @(negedge clk);
        addr  = BASE + 64'(off);
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        case (off)
            'h00: m_pend = m_pend & ~d[N-1:0];
            'h08: m_en   = d[N-1:0];
`ifdef IRQ_LEVEL_MODE_EN
            'h18: m_mode = d[N-1:0];
`endif
            default: ;
        endcase
        for (int k = 0; k < int'(N); k++) if (m_mode[k]) m_pend[k] = m_lvl[k];
        try_present();
        @(negedge clk);
    endtask

    task automatic bus_read(input int off);
        bit hit;
        hit = (off < 32);
        if (hit) rd_q.push_back(m_read(off));
        @(negedge clk);
        addr = BASE + 64'(off);
        re   = 1'b1;
        @(negedge clk);
        re = 1'b0;
        if (!hit) check("rd_miss_done", 64'(rdone), 64'd0);
        @(negedge clk);
        check("rd_done_drop", 64'(rdone), 64'd0);
    endtask

    // One-cycle source pulse; vector must be settled 4 cycles after the edge.
    task automatic pulse(input logic [N-1:0] m);
        @(negedge clk);
        irq_src = m;
        m_pend  = m_pend | m;
        try_present();
        @(negedge clk);
        irq_src = '0;
        repeat (3) @(negedge clk);
        check("pulse_vec", 64'(vec), 64'(m_vec()));
    endtask

    task automatic do_ack(input int hold, input bit repulse);
        int cur;
        cur = m_cur;
        @(negedge clk);
        ack = 1'b1;
        m_pend[cur] = 1'b0;
        if (m_mode[cur]) m_pend[cur] = m_lvl[cur];
        m_cur = -1;
        m_blocked = 1'b1;
        vec_q.push_back('0);
        @(negedge clk);
        check("ack_vec_zero", 64'(vec), 64'd0);
        if (repulse) pulse(N'(1) << cur);
        repeat (hold) @(negedge clk);
        check("ack_held_vec", 64'(vec), 64'd0);
        ack = 1'b0;
        m_blocked = 1'b0;
        try_present();
        repeat (3) @(negedge clk);
        check("ack_release_vec", 64'(vec), 64'(m_vec()));
    endtask

    initial begin
        addr = BASE;
        repeat (2) @(negedge clk);
        check("rst_vec", 64'(vec), 64'd0);
        check("rst_done", 64'(rdone), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single source, full handshake.
        bus_write('h08, 64'hF);
        pulse(4'b0100);
        check("tp1_vec3", 64'(vec), 64'd3);
        bus_read('h00);
        do_ack(0, 1'b0);
        bus_read('h00);

        // Two sources together: lower index first.
        pulse(4'b1010);
        check("tp2_vec2", 64'(vec), 64'd2);
        do_ack(1, 1'b0);
        check("tp2_vec4", 64'(vec), 64'd4);
        do_ack(1, 1'b0);
        check("tp2_vec0", 64'(vec), 64'd0);

        // Masked request, then enable, then W1C while presented.
        bus_write('h08, 64'h0);
        pulse(4'b0001);
        check("tp3_masked", 64'(vec), 64'd0);
        bus_read('h00);
        bus_write('h08, 64'h1);
        check("tp3_vec1", 64'(vec), 64'd1);
        bus_write('h00, 64'h1);
        bus_read('h00);
        check("tp3_w1c_hold", 64'(vec), 64'd1);
        do_ack(2, 1'b0);

        // Long ack with a re-pulse: exactly one presentation after release.
        pulse(4'b0001);
        do_ack(10, 1'b1);
        check("tp4_vec1", 64'(vec), 64'd1);
        do_ack(0, 1'b0);

        // ACTIVE readback.
        bus_write('h08, 64'hF);
        pulse(4'b0010);
        bus_read('h10);
        bus_write('h10, 64'hFF);
        bus_read('h18);
        bus_read('h20);
        do_ack(0, 1'b0);

`ifndef IRQ_LEVEL_MODE_EN
        bus_write('h18, 64'hF);
        bus_read('h18);
`else
        // Level-sensitive source 0.
        bus_write('h18, 64'h1);
        @(negedge clk);
        irq_src[0] = 1'b1;
        m_lvl[0] = 1'b1;
        m_pend[0] = 1'b1;
        try_present();
        repeat (5) @(negedge clk);
        check("lvl_vec1", 64'(vec), 64'd1);
        do_ack(3, 1'b0);
        check("lvl_repres", 64'(vec), 64'd1);
        @(negedge clk);
        irq_src[0] = 1'b0;
        m_lvl[0] = 1'b0;
        m_pend[0] = 1'b0;
        repeat (3) @(negedge clk);
        bus_read('h00);
        do_ack(0, 1'b0);
        bus_write('h18, 64'h0);
`endif

        // Reset while presenting.
        pulse(4'b1000);
        @(negedge clk);
        #2;
        vec_q.push_back('0);
        rst_n = 1'b0;
        #1;
        check("midrst_vec", 64'(vec), 64'd0);
        m_pend = '0; m_en = '0; m_mode = '0; m_cur = -1; m_blocked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read('h00);
        bus_read('h08);

        // Randomised traffic.
        bus_write('h08, 64'(4'($urandom)));
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: pulse(N'($urandom_range(1, 15)));
                1: bus_write('h08, 64'($urandom));
                2: bus_write('h00, 64'($urandom));
                3: begin
                    if (m_cur >= 0) do_ack($urandom_range(0, 5), 1'($urandom));
                    else pulse(N'($urandom_range(1, 15)));
                end
                4: bus_read(8 * $urandom_range(0, 4));
                default: bus_write('h10, 64'($urandom));
            endcase
        end

        repeat (5) @(negedge clk);
        check("vec_q_empty", 64'(vec_q.size()), 64'd0);
        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
